// File: rtl/k_pc_sequencer.sv
// k_pc_sequencer
//   Next-PC controller for the K_DSP fetch path. Owns the program counter and selects,
//   each cycle, between sequential increment, a taken branch, or a zero-overhead
//   hardware-loop back-edge taken from a small stack of {start, end, count} entries.
//
// Ports
//   clk            in   sole clock, rising edge
//   reset          in   synchronous, active-high; empties the loop stack
//   stall          in   hold all state this cycle (redirect drops to 0)
//   br_valid       in   taken branch/jump this cycle
//   br_target      in   branch destination
//   loop_start     in   instruction at pc_reg is a LOOP
//   loop_end_addr  in   address of the last loop-body instruction (inclusive)
//   loop_count     in   loop iteration count
//   pc_reg         out  current fetch PC
//   redirect       out  pc_reg changed non-sequentially this cycle
//   loop_active    out  loop stack non-empty
//   loop_depth     out  number of occupied stack entries
//   loop_err       out  sticky error (stack overflow or LOOP at a loop end)
module k_pc_sequencer #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned PC_INC     = 4,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned LOOP_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall,
    input  logic                               br_valid,
    input  logic [ADDR_W-1:0]                  br_target,
    input  logic                               loop_start,
    input  logic [ADDR_W-1:0]                  loop_end_addr,
    input  logic [CNT_W-1:0]                   loop_count,
    output logic [ADDR_W-1:0]                  pc_reg,
    output logic                               redirect,
    output logic                               loop_active,
    output logic [$clog2(LOOP_DEPTH+1)-1:0]    loop_depth,
    output logic                               loop_err
);

    localparam int unsigned DepW = $clog2(LOOP_DEPTH + 1);
    localparam int unsigned IdxW = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

    localparam logic [ADDR_W-1:0] PcInc   = ADDR_W'(PC_INC);
    localparam logic [ADDR_W-1:0] PcReset = ADDR_W'(RESET_PC);
    localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CntZero = '0;
    localparam logic [DepW-1:0]   DepOne  = DepW'(1);
    localparam logic [DepW-1:0]   DepFull = DepW'(LOOP_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              redirect_q, redirect_d;
    logic [DepW-1:0]   depth_q, depth_d;
    logic              err_q, err_d;

    // Stack storage; contents are don't-care while unoccupied, so no reset.
    logic [ADDR_W-1:0] start_q [LOOP_DEPTH];
    logic [ADDR_W-1:0] start_d [LOOP_DEPTH];
    logic [ADDR_W-1:0] end_q   [LOOP_DEPTH];
    logic [ADDR_W-1:0] end_d   [LOOP_DEPTH];
    logic [CNT_W-1:0]  cnt_q   [LOOP_DEPTH];
    logic [CNT_W-1:0]  cnt_d   [LOOP_DEPTH];

    logic [IdxW-1:0]   top_idx;
    logic [IdxW-1:0]   push_idx;
    logic [ADDR_W-1:0] pc_seq;
    logic              stack_empty;
    logic              stack_full;
    logic              at_end;

    always_comb begin
        stack_empty = (depth_q == '0);
        stack_full  = (depth_q == DepFull);
        // Only meaningful when the stack is non-empty / not full respectively.
        top_idx     = IdxW'(depth_q - DepOne);
        push_idx    = IdxW'(depth_q);
        pc_seq      = pc_q + PcInc;
        // Only the innermost (top) loop end is compared.
        at_end      = !stack_empty && (pc_q == end_q[top_idx]);
    end

    always_comb begin
        pc_d       = pc_q;
        redirect_d = 1'b0;
        depth_d    = depth_q;
        err_d      = err_q;
        start_d    = start_q;
        end_d      = end_q;
        cnt_d      = cnt_q;

        if (!stall) begin
            if (br_valid) begin
                // Stack left alone: leaving loops by branch is up to software.
                pc_d       = br_target;
                redirect_d = 1'b1;
            end else if (at_end) begin
                if (loop_start) begin
                    err_d = 1'b1;
                end
                if (cnt_q[top_idx] > CntOne) begin
                    cnt_d[top_idx] = cnt_q[top_idx] - CntOne;
                    pc_d           = start_q[top_idx];
                    redirect_d     = 1'b1;
                end else begin
                    depth_d = depth_q - DepOne;
                    pc_d    = pc_seq;
                end
            end else if (loop_start) begin
                if (loop_count == CntZero) begin
                    // Zero-trip loop: skip the body entirely.
                    pc_d       = loop_end_addr + PcInc;
                    redirect_d = 1'b1;
                end else if (stack_full) begin
                    err_d = 1'b1;
                    pc_d  = pc_seq;
                end else begin
                    start_d[push_idx] = pc_seq;
                    end_d[push_idx]   = loop_end_addr;
                    cnt_d[push_idx]   = loop_count;
                    depth_d           = depth_q + DepOne;
                    pc_d              = pc_seq;
                end
            end else begin
                pc_d = pc_seq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= PcReset;
            redirect_q <= 1'b0;
            depth_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            depth_q    <= depth_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        start_q <= start_d;
        end_q   <= end_d;
        cnt_q   <= cnt_d;
    end

    assign pc_reg      = pc_q;
    assign redirect    = redirect_q;
    assign loop_depth  = depth_q;
    assign loop_active = !stack_empty;
    assign loop_err    = err_q;

endmodule

// File: tb/tb_k_pc_sequencer.sv
module tb_k_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, stall, br_valid, loop_start;
    logic [31:0] br_target, loop_end_addr;
    logic [15:0] loop_count;
    logic [31:0] pc_reg;
    logic        redirect, loop_active, loop_err;
    logic [2:0]  loop_depth;

    always #5 clk = ~clk;

    k_pc_sequencer #(
        .ADDR_W    (32),
        .PC_INC    (4),
        .RESET_PC  (0),
        .LOOP_DEPTH(4),
        .CNT_W     (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .loop_start   (loop_start),
        .loop_end_addr(loop_end_addr),
        .loop_count   (loop_count),
        .pc_reg       (pc_reg),
        .redirect     (redirect),
        .loop_active  (loop_active),
        .loop_depth   (loop_depth),
        .loop_err     (loop_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t,
                         input logic ls, input logic [31:0] le, input logic [15:0] lc);
        reset = r; stall = s; br_valid = b; br_target = t;
        loop_start = ls; loop_end_addr = le; loop_count = lc;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic red,
                           input logic [2:0] dep, input logic err);
        chk({tag, ".pc"}, pc_reg, pc);
        chk({tag, ".redirect"}, {31'b0, redirect}, {31'b0, red});
        chk({tag, ".depth"}, {29'b0, loop_depth}, {29'b0, dep});
        chk({tag, ".active"}, {31'b0, loop_active}, {31'b0, (dep != 3'd0)});
        chk({tag, ".err"}, {31'b0, loop_err}, {31'b0, err});
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, stl, br, ls;
        logic [31:0] tgt, le;
        logic [15:0] lc;
        logic [31:0] pc;
        logic        red;
        logic [2:0]  dep;
        logic        err;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic rst, input logic stl, input logic br,
                                input logic [31:0] tgt, input logic ls, input logic [31:0] le,
                                input logic [15:0] lc, input logic [31:0] pc, input logic red,
                                input logic [2:0] dep, input logic err);
        vec_t v;
        v.rst = rst; v.stl = stl; v.br = br; v.tgt = tgt; v.ls = ls; v.le = le; v.lc = lc;
        v.pc = pc; v.red = red; v.dep = dep; v.err = err;
        vecs.push_back(v);
    endfunction

    function automatic void a_rst();
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic void a_idle(input logic [31:0] pc, input logic red, input logic [2:0] dep,
                                   input logic err);
        add(0, 0, 0, 0, 0, 0, 0, pc, red, dep, err);
    endfunction
    function automatic void a_br(input logic [31:0] tgt, input logic [2:0] dep, input logic err);
        add(0, 0, 1, tgt, 0, 0, 0, tgt, 1, dep, err);
    endfunction
    function automatic void a_ls(input logic [31:0] le, input logic [15:0] lc,
                                 input logic [31:0] pc, input logic red, input logic [2:0] dep,
                                 input logic err);
        add(0, 0, 0, 0, 1, le, lc, pc, red, dep, err);
    endfunction
    // Stall with branch and loop_start asserted: both must be ignored.
    function automatic void a_stall(input logic [31:0] pc, input logic [2:0] dep, input logic err);
        add(0, 1, 1, 32'h999, 1, 32'h700, 16'd5, pc, 0, dep, err);
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] s;
        logic [31:0] e;
        int unsigned c;
    } ent_t;
    ent_t        stk[$];
    logic [31:0] m_pc;
    logic        m_red, m_err;

    task automatic model_step(input logic r, input logic s, input logic b, input logic [31:0] t,
                              input logic ls, input logic [31:0] le, input logic [15:0] lc);
        ent_t top;
        if (r) begin
            m_pc = 0; m_red = 0; m_err = 0; stk.delete();
            return;
        end
        m_red = 0;
        if (s) return;
        if (b) begin
            m_pc = t; m_red = 1;
        end else if (stk.size() > 0 && m_pc == stk[stk.size()-1].e) begin
            if (ls) m_err = 1;
            top = stk[stk.size()-1];
            if (top.c > 1) begin
                top.c = top.c - 1;
                stk[stk.size()-1] = top;
                m_pc = top.s; m_red = 1;
            end else begin
                void'(stk.pop_back());
                m_pc = m_pc + 32'd4;
            end
        end else if (ls) begin
            if (lc == 0) begin
                m_pc = le + 32'd4; m_red = 1;
            end else if (stk.size() == 4) begin
                m_err = 1; m_pc = m_pc + 32'd4;
            end else begin
                top.s = m_pc + 32'd4; top.e = le; top.c = lc;
                stk.push_back(top);
                m_pc = m_pc + 32'd4;
            end
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        logic        r, s, b, ls;
        logic [31:0] t, le;
        logic [15:0] lc;

        // Reset then free-run; reset mid-run returns to 0.
        a_rst();
        for (int k = 1; k <= 5; k++) a_idle(32'(4 * k), 0, 0, 0);
        a_rst();
        for (int k = 1; k <= 4; k++) a_idle(32'(4 * k), 0, 0, 0);
        // Branch at 0x10.
        a_br(32'h100, 0, 0);
        a_idle(32'h104, 0, 0, 0);
        // Loop 0x24..0x28 x3.
        a_br(32'h20, 0, 0);
        a_ls(32'h28, 3, 32'h24, 0, 1, 0);
        a_idle(32'h28, 0, 1, 0);
        a_idle(32'h24, 1, 1, 0);
        a_idle(32'h28, 0, 1, 0);
        a_idle(32'h24, 1, 1, 0);
        a_idle(32'h28, 0, 1, 0);
        a_idle(32'h2C, 0, 0, 0);
        // Zero-count loop skips to end+4.
        a_ls(32'h40, 0, 32'h44, 1, 0, 0);
        // Stall while at loop end.
        a_br(32'h50, 0, 0);
        a_ls(32'h58, 2, 32'h54, 0, 1, 0);
        a_idle(32'h58, 0, 1, 0);
        a_stall(32'h58, 1, 0);
        a_stall(32'h58, 1, 0);
        a_stall(32'h58, 1, 0);
        a_idle(32'h54, 1, 1, 0);
        a_idle(32'h58, 0, 1, 0);
        a_idle(32'h5C, 0, 0, 0);
        // Branch beats loop end; stack untouched.
        a_ls(32'h60, 2, 32'h60, 0, 1, 0);
        a_br(32'h200, 1, 0);
        // loop_start at a loop end: back-edge still taken, error set.
        a_br(32'h60, 1, 0);
        a_ls(32'h80, 5, 32'h60, 1, 1, 1);
        a_idle(32'h64, 0, 0, 1);
        a_rst();
        // Wrap-around.
        a_br(32'hFFFF_FFFC, 0, 0);
        a_idle(32'h0, 0, 0, 0);
        // Overflow on fifth push.
        a_ls(32'h1000, 2, 32'h4, 0, 1, 0);
        a_ls(32'h1000, 2, 32'h8, 0, 2, 0);
        a_ls(32'h1000, 2, 32'hC, 0, 3, 0);
        a_ls(32'h1000, 2, 32'h10, 0, 4, 0);
        a_ls(32'h1000, 2, 32'h14, 0, 4, 1);
        a_rst();
        // Nested: outer 0x104..0x110 x2, inner 0x108..0x10C x2.
        a_br(32'h100, 0, 0);
        a_ls(32'h110, 2, 32'h104, 0, 1, 0);
        for (int n = 0; n < 2; n++) begin
            if (n == 1) a_ls(32'h10C, 2, 32'h108, 0, 2, 0);
            else a_ls(32'h10C, 2, 32'h108, 0, 2, 0);
            a_idle(32'h10C, 0, 2, 0);
            a_idle(32'h108, 1, 2, 0);
            a_idle(32'h10C, 0, 2, 0);
            a_idle(32'h110, 0, 1, 0);
            if (n == 0) a_idle(32'h104, 1, 1, 0);
            else a_idle(32'h114, 0, 0, 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].tgt, vecs[i].ls, vecs[i].le,
                  vecs[i].lc);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].red, vecs[i].dep, vecs[i].err);
        end

        // One-instruction body (end == start) repeats the same PC for N cycles.
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 32'h4, 16'd3);
        tick();
        chk_all("one.0", 32'h4, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_all("one.1", 32'h4, 1, 1, 0);
        tick();
        chk_all("one.2", 32'h4, 1, 1, 0);
        tick();
        chk_all("one.3", 32'h8, 0, 0, 0);

        // Randomized run against the reference model.
        drive(1, 0, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0, 0);
        tick();
        chk_all("rnd.rst", m_pc, m_red, 3'(stk.size()), m_err);
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 149) == 0);
            s  = ($urandom_range(0, 7) == 0);
            b  = ($urandom_range(0, 15) == 0);
            t  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            ls = ($urandom_range(0, 4) == 0);
            le = m_pc + 32'(4 * $urandom_range(0, 5));
            lc = 16'($urandom_range(0, 3));
            drive(r, s, b, t, ls, le, lc);
            model_step(r, s, b, t, ls, le, lc);
            tick();
            chk_all($sformatf("rnd%0d", n), m_pc, m_red, 3'(stk.size()), m_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
